// File: rtl/uart_rx_if.sv
// Serial receive link bundle: raw RX line in, received byte plus valid strobe out.
// master: line driver / byte consumer side; slave: the receiver itself.
// No backpressure; the valid strobe is a one-clock pulse.
interface uart_rx_if;
  logic       i_rx_bit;         // raw serial line, idles high, asynchronous
  logic       o_rx_data_valid;  // one-clock pulse per correctly framed byte
  logic [7:0] o_rx_byte;        // last correctly framed byte

  modport master (
    output i_rx_bit,
    input  o_rx_data_valid,
    input  o_rx_byte
  );

  modport slave (
    input  i_rx_bit,
    output o_rx_data_valid,
    output o_rx_byte
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples the line at mid-bit and emits each good byte.
// Latency: about 3 + (CLOCKS_PER_BIT-1)/2 + 1 + 9*CLOCKS_PER_BIT clocks from the start edge to valid.
// Backpressure: none; the consumer captures o_rx_byte on the valid pulse or before the next frame ends.
// Ports: i_clk (system clock), i_rst_n (async active-low reset),
//        rx.i_rx_bit (serial line), rx.o_rx_data_valid / rx.o_rx_byte (parallel result).
module uart_rx #(
  parameter int CLOCKS_PER_BIT = 1302
) (
  input logic      i_clk,
  input logic      i_rst_n,
  uart_rx_if.slave rx
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLOCKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             rx_s;

  // Two-flop synchronizer; resets to the idle (high) line level so reset
  // release never looks like a start bit.
  assign sync_d = {sync_q[0], rx.i_rx_bit};
  assign rx_s   = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        // Recheck the line at the start-bit midpoint to reject glitches.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DATA: begin
        // Counter was zeroed at the start midpoint, so each full count lands mid-bit.
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = CLEANUP;
          // A low stop bit is a framing error: drop the byte silently.
          if (rx_s) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      CLEANUP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
    end
  end

  assign rx.o_rx_data_valid = valid_q;
  assign rx.o_rx_byte       = byte_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one instance at the default 1302 clocks/bit and one at 16.
// Random and directed 8N1 frames are driven serially; received bytes are compared
// against a queue of bytes expected from the framing rules.
module tb_uart_rx;

  localparam int CPB_A = 1302;
  localparam int CPB_B = 16;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  uart_rx_if ifa ();
  uart_rx_if ifb ();

  uart_rx #(.CLOCKS_PER_BIT(CPB_A)) dut_a (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .rx     (ifa)
  );

  uart_rx #(.CLOCKS_PER_BIT(CPB_B)) dut_b (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .rx     (ifb)
  );

  // 50 MHz
  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Receive monitors: log every valid pulse and track the longest run of valid.
  logic [7:0] got_a[$];
  logic [7:0] got_b[$];
  int         cyc_a[$];
  int         run_a, run_b, max_run_a, max_run_b;

  initial begin
    run_a = 0; run_b = 0; max_run_a = 0; max_run_b = 0;
  end

  always @(negedge clk) begin
    if (ifa.o_rx_data_valid === 1'b1) begin
      got_a.push_back(ifa.o_rx_byte);
      cyc_a.push_back(cyc);
      run_a = run_a + 1;
      if (run_a > max_run_a) max_run_a = run_a;
    end else begin
      run_a = 0;
    end
    if (ifb.o_rx_data_valid === 1'b1) begin
      got_b.push_back(ifb.o_rx_byte);
      run_b = run_b + 1;
      if (run_b > max_run_b) max_run_b = run_b;
    end else begin
      run_b = 0;
    end
  end

  // Reference model state for instance B.
  logic [7:0] exp_b[$];
  logic [7:0] last_good_b;

  // ---------------- stimulus helpers ----------------
  task automatic hold_a(input logic v, input int n);
    ifa.i_rx_bit = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold_b(input logic v, input int n);
    ifb.i_rx_bit = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(input logic [7:0] b);
    hold_a(1'b0, CPB_A);
    for (int i = 0; i < 8; i++) hold_a(b[i], CPB_A);
    hold_a(1'b1, CPB_A);
  endtask

  // Sends one frame; the model records the byte only when the stop bit is high.
  task automatic send_b(input logic [7:0] b, input logic stop);
    hold_b(1'b0, CPB_B);
    for (int i = 0; i < 8; i++) hold_b(b[i], CPB_B);
    hold_b(stop, CPB_B);
    if (stop) begin
      exp_b.push_back(b);
      last_good_b = b;
    end
  endtask

  task automatic clear_b();
    got_b.delete();
    exp_b.delete();
    max_run_b = 0;
  endtask

  // Compare everything instance B produced against the model queue.
  task automatic check_b(input string name);
    total++;
    if (got_b.size() !== exp_b.size()) begin
      bad++;
      $display("FAIL %s count: got %0d pulses, expected %0d", name, got_b.size(), exp_b.size());
    end
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
      total++;
      if (got_b[i] !== exp_b[i]) begin
        bad++;
        $display("FAIL %s byte[%0d]: got %02h, expected %02h", name, i, got_b[i], exp_b[i]);
      end
    end
    total++;
    if (ifb.o_rx_byte !== last_good_b) begin
      bad++;
      $display("FAIL %s held byte: got %02h, expected %02h", name, ifb.o_rx_byte, last_good_b);
    end
    if (exp_b.size() > 0) begin
      total++;
      if (max_run_b !== 1) begin
        bad++;
        $display("FAIL %s pulse width: got %0d clocks, expected 1", name, max_run_b);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int errs;
    errs = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ifa.i_rx_bit = 1'($urandom_range(0, 1));
      ifb.i_rx_bit = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ifa.o_rx_data_valid !== 1'b0 || ifa.o_rx_byte !== 8'h00 ||
          ifb.o_rx_data_valid !== 1'b0 || ifb.o_rx_byte !== 8'h00) begin
        errs++;
      end
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL reset_hold: %0d cycles with outputs off (a=%b/%02h b=%b/%02h), expected valid=0 byte=00",
               errs, ifa.o_rx_data_valid, ifa.o_rx_byte, ifb.o_rx_data_valid, ifb.o_rx_byte);
    end
    ifa.i_rx_bit = 1'b1;
    ifb.i_rx_bit = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold_b(1'b1, 8);
    total++;
    if (got_a.size() + got_b.size() !== 0) begin
      bad++;
      $display("FAIL reset_release: got %0d pulses, expected 0", got_a.size() + got_b.size());
    end
    last_good_b = 8'h00;
    clear_b();
  endtask

  task automatic test_default_frame();
    int fall_cyc;
    int lat;
    int exp_lat;
    int k;
    got_a.delete();
    cyc_a.delete();
    max_run_a = 0;
    fall_cyc = cyc;
    send_a(8'h3F);
    k = 0;
    while (got_a.size() == 0 && k < 2 * CPB_A) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (got_a.size() != 1) begin
      bad++;
      $display("FAIL default_count: got %0d pulses, expected 1", got_a.size());
    end else begin
      total++;
      if (got_a[0] !== 8'h3F) begin
        bad++;
        $display("FAIL default_byte: got %02h, expected 3f", got_a[0]);
      end
      exp_lat = 3 + ((CPB_A - 1) / 2 + 1) + 9 * CPB_A;
      lat = cyc_a[0] - fall_cyc;
      total++;
      if (lat < exp_lat - 1 || lat > exp_lat + 1) begin
        bad++;
        $display("FAIL default_latency: got %0d clocks, expected %0d +-1", lat, exp_lat);
      end
    end
    total++;
    if (max_run_a !== 1) begin
      bad++;
      $display("FAIL default_pulse_width: got %0d clocks, expected 1", max_run_a);
    end
    // 20 us after the frame ends
    hold_a(1'b1, 1000);
    total++;
    if (ifa.o_rx_byte !== 8'h3F || got_a.size() != 1) begin
      bad++;
      $display("FAIL default_hold: got byte %02h with %0d pulses, expected 3f with 1", ifa.o_rx_byte, got_a.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_b();
    send_b(8'h00, 1'b1);
    send_b(8'hFF, 1'b1);
    send_b(8'hA5, 1'b1);
    send_b(8'h5A, 1'b1);
    for (int i = 0; i < 10; i++) send_b(8'($urandom_range(0, 255)), 1'b1);
    hold_b(1'b1, 2 * CPB_B);
    check_b("back_to_back");
  endtask

  task automatic test_glitch();
    clear_b();
    hold_b(1'b1, CPB_B);
    hold_b(1'b0, 5);
    hold_b(1'b1, 3 * CPB_B);
    check_b("glitch_reject");
    clear_b();
    send_b(8'hC3, 1'b1);
    hold_b(1'b1, CPB_B);
    check_b("glitch_then_c3");
  endtask

  task automatic test_framing();
    logic [7:0] b;
    logic       stop;
    clear_b();
    send_b(8'h81, 1'b0);
    hold_b(1'b1, 2 * CPB_B);
    check_b("framing_error");
    clear_b();
    send_b(8'h7E, 1'b1);
    hold_b(1'b1, CPB_B);
    check_b("framing_then_7e");
    // Random mix of good and bad stop bits.
    clear_b();
    for (int i = 0; i < 12; i++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send_b(b, stop);
      if (!stop) hold_b(1'b1, CPB_B);
    end
    hold_b(1'b1, 2 * CPB_B);
    check_b("framing_random");
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    b = 8'h55;
    clear_b();
    hold_b(1'b0, CPB_B);
    for (int i = 0; i < 4; i++) hold_b(b[i], CPB_B);
    hold_b(b[4], CPB_B / 2);
    rst_n = 1'b0;
    #3;
    total++;
    if (ifb.o_rx_byte !== 8'h00 || ifb.o_rx_data_valid !== 1'b0) begin
      bad++;
      $display("FAIL midframe_reset_outputs: got valid=%b byte=%02h, expected 0/00",
               ifb.o_rx_data_valid, ifb.o_rx_byte);
    end
    hold_b(b[4], 3);
    rst_n = 1'b1;
    last_good_b = 8'h00;
    hold_b(1'b1, 3 * CPB_B);
    check_b("midframe_no_spurious");
    clear_b();
    send_b(8'h12, 1'b1);
    hold_b(1'b1, CPB_B);
    check_b("midframe_then_12");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    ifa.i_rx_bit = 1'b1;
    ifb.i_rx_bit = 1'b1;
    last_good_b  = 8'h00;
    #5;
    test_reset();
    test_default_frame();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
